// File: rtl/hack_cpu_control.sv
// hack_cpu_control
// Control and sequencing unit for the command side of a 16-bit Hack ALU.
// Fetches one instruction per handshake, then spends exactly one EXEC
// cycle driving the external ALU and committing A, D, PC and memory writes.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   instr, instr_valid    instruction word for address pc and its valid flag
//   instr_ready           high in FETCH when an instruction can be taken
//   inM                   data-memory read value at addressM (used in EXEC)
//   alu_x, alu_y          ALU operands (D, and A or inM)
//   zx,nx,zy,ny,f,no      ALU control bits, non-zero only in EXEC of a C-instr
//   alu_out, zr, ng       ALU result and its flags
//   outM, writeM          data-memory write value and strobe
//   addressM              data-memory address (A[14:0], pre-update)
//   pc                    instruction fetch address
module hack_cpu_control #(
   parameter logic [14:0] RST_PC = 15'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] inM,
   output logic [15:0] alu_x,
   output logic [15:0] alu_y,
   output logic        zx,
   output logic        nx,
   output logic        zy,
   output logic        ny,
   output logic        f,
   output logic        no,
   input  logic [15:0] alu_out,
   input  logic        zr,
   input  logic        ng,
   output logic [15:0] outM,
   output logic        writeM,
   output logic [14:0] addressM,
   output logic [14:0] pc
);

   typedef enum logic {FETCH, EXEC} state_t;

   state_t      state, state_nxt;
   logic [15:0] ir;
   logic [15:0] a_reg;
   logic [15:0] d_reg;
   logic [14:0] pc_reg;

   logic        is_c;
   logic        exec_act;
   logic        jump;

   assign is_c = ir[15];

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_nxt;
   end

   // Next state and control outputs
   always_comb begin
      state_nxt   = state;
      instr_ready = 1'b0;
      exec_act    = 1'b0;
      {zx, nx, zy, ny, f, no} = 6'b0;
      case (state)
         FETCH: begin
            instr_ready = ~reset;
            if (instr_valid) state_nxt = EXEC;
         end
         EXEC: begin
            state_nxt = FETCH;
            // reset during EXEC cancels every side effect of the instruction
            exec_act  = ~reset;
            if (exec_act && is_c) {zx, nx, zy, ny, f, no} = ir[11:6];
         end
         default: state_nxt = FETCH;
      endcase
   end

   // Datapath outputs; the a-bit only selects inM for C-instructions
   assign alu_x    = d_reg;
   assign alu_y    = (is_c && ir[12]) ? inM : a_reg;
   assign addressM = a_reg[14:0];
   assign pc       = pc_reg;
   assign writeM   = exec_act && is_c && ir[3];
   assign outM     = writeM ? alu_out : 16'h0000;

   assign jump = is_c && ((ir[2] && ng) || (ir[1] && zr) || (ir[0] && !ng && !zr));

   // Architectural registers; jump target and memory address both see old A
   always_ff @(posedge clk) begin
      if (reset) begin
         ir     <= 16'h0000;
         a_reg  <= 16'h0000;
         d_reg  <= 16'h0000;
         pc_reg <= RST_PC;
      end else begin
         if (state == FETCH && instr_valid) ir <= instr;
         if (state == EXEC) begin
            if (!is_c) begin
               a_reg <= ir;
            end else begin
               if (ir[5]) a_reg <= alu_out;
               if (ir[4]) d_reg <= alu_out;
            end
            pc_reg <= jump ? a_reg[14:0] : pc_reg + 15'd1;
         end
      end
   end

endmodule
